mem_stage_ctrl: RTL

Memory-stage controller that sits between the X/M pipeline latch and the M/W latch of the five-stage processor. It decodes the instruction held in X/M and issues lw/sw accesses to data memory over a req/ack handshake. While an access is outstanding it asserts `stall` to freeze the upstream stages. It also registers the stage result (ALU value or load data) toward writeback.

---
 rtl/mem_stage_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller between the X/M and M/W latches.
// Issues lw/sw over a req/ack handshake, stalls upstream while busy, and times out abandoned accesses.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_IR,
  input  logic [31:0]       data_in_O,
  input  logic [31:0]       data_in_B,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              stall,
  output logic              out_valid,
  output logic [31:0]       out_IR,
  output logic [31:0]       data_out_O,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      hold_ir;
  logic [31:0]      hold_o;
  logic             is_sw, is_lw, is_mem;
  logic             timeout_hit;

  assign is_sw  = (in_IR[31:27] == 5'b00111);
  assign is_lw  = (in_IR[31:27] == 5'b01000);
  assign is_mem = in_valid & (is_sw | is_lw);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (is_mem) next_state = BUSY;
      BUSY: if (mem_ack || timeout_hit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Ack takes priority over timeout, so timeout_hit excludes an acked last cycle.
  always_comb begin
    timeout_hit = (state == BUSY) && !mem_ack && (wait_cnt == CNT_LAST);
    stall       = ((state == IDLE) && is_mem) ||
                  ((state == BUSY) && !mem_ack && !timeout_hit);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt   <= '0;
      hold_ir    <= '0;
      hold_o     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      out_valid  <= 1'b0;
      out_IR     <= '0;
      data_out_O <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            mem_req    <= 1'b1;
            mem_we     <= is_sw;
            mem_addr   <= data_in_O[ADDR_W-1:0];
            mem_wdata  <= data_in_B;
            hold_ir    <= in_IR;
            hold_o     <= data_in_O;
            wait_cnt   <= '0;
            out_valid  <= 1'b0;
            out_IR     <= '0;
            data_out_O <= '0;
          end else begin
            out_valid  <= in_valid;
            out_IR     <= in_valid ? in_IR : 32'h0;
            data_out_O <= in_valid ? data_in_O : 32'h0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            out_valid  <= 1'b1;
            out_IR     <= hold_ir;
            data_out_O <= mem_we ? hold_o : mem_rdata;
          end else if (timeout_hit) begin
            // Abandoned load completes with zero data so the pipeline keeps moving.
            mem_req    <= 1'b0;
            err        <= 1'b1;
            out_valid  <= 1'b1;
            out_IR     <= hold_ir;
            data_out_O <= mem_we ? hold_o : 32'h0;
          end else begin
            wait_cnt   <= wait_cnt + 1'b1;
            out_valid  <= 1'b0;
            out_IR     <= '0;
            data_out_O <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
